// File: rtl/flag_cond_unit.sv
// rtl/flag_cond_unit.sv - flag register, LIFO flag stack and tttn condition evaluator
// Sits between the adder flag outputs and the branch unit.
module flag_cond_unit #(
    parameter int STK_DEPTH = 4,
    parameter int STK_AW    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flg_we,
    input  logic              sf_in,
    input  logic              cf_in,
    input  logic              of_in,
    input  logic              pf_in,
    input  logic              zf_in,
    input  logic              push,
    input  logic              pop,
    input  logic              cond_valid,
    input  logic [3:0]        cond_code,
    output logic              cond_ready,
    output logic              take_valid,
    output logic              take,
    input  logic              take_ack,
    output logic [4:0]        flags_out,
    output logic [STK_AW:0]   stk_cnt,
    output logic              stk_full,
    output logic              stk_empty,
    output logic              stk_err
);
    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

    localparam logic [STK_AW:0] DEPTH_C = (STK_AW+1)'(STK_DEPTH);

    state_t          state;
    logic            eval_ph;
    logic [3:0]      code_q;
    logic [4:0]      stk [STK_DEPTH];
    logic [STK_AW:0] cnt_m1;
    logic [4:0]      stk_top;
    logic            push_ok;
    logic            pop_ok;
    logic            err_now;

    assign stk_full  = (stk_cnt == DEPTH_C);
    assign stk_empty = (stk_cnt == '0);
    assign cnt_m1    = stk_cnt - 1'b1;
    assign stk_top   = stk[cnt_m1[STK_AW-1:0]];
    assign push_ok   = push & ~pop & ~stk_full;
    assign pop_ok    = pop & ~push & ~stk_empty;
    assign err_now   = (push & pop) | (push & stk_full) | (pop & stk_empty);

    // f = {SF,CF,OF,PF,ZF}; odd codes negate the even condition
    function automatic logic cond_eval(input logic [3:0] c, input logic [4:0] f);
        logic r;
        case (c[3:1])
            3'd0:    r = f[2];
            3'd1:    r = f[3];
            3'd2:    r = f[0];
            3'd3:    r = f[3] | f[0];
            3'd4:    r = f[4];
            3'd5:    r = f[1];
            3'd6:    r = f[4] ^ f[2];
            default: r = f[0] | (f[4] ^ f[2]);
        endcase
        return r ^ c[0];
    endfunction

    // Stack RAM is not reset; stk_cnt alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            stk[stk_cnt[STK_AW-1:0]] <= flags_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_out <= '0;
            stk_cnt   <= '0;
            stk_err   <= 1'b0;
        end else begin
            stk_err <= err_now;
            if (pop_ok) begin
                flags_out <= stk_top;
                stk_cnt   <= cnt_m1;
            end else begin
                if (flg_we) begin
                    flags_out <= {sf_in, cf_in, of_in, pf_in, zf_in};
                end
                if (push_ok) begin
                    stk_cnt <= stk_cnt + 1'b1;
                end
            end
        end
    end

    // EVAL spans two cycles: the first samples FR, the second raises take_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            eval_ph    <= 1'b0;
            code_q     <= '0;
            cond_ready <= 1'b1;
            take_valid <= 1'b0;
            take       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cond_valid) begin
                        code_q     <= cond_code;
                        cond_ready <= 1'b0;
                        eval_ph    <= 1'b0;
                        state      <= EVAL;
                    end
                end
                EVAL: begin
                    if (!eval_ph) begin
                        take    <= cond_eval(code_q, flags_out);
                        eval_ph <= 1'b1;
                    end else begin
                        eval_ph    <= 1'b0;
                        take_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (take_ack) begin
                        take_valid <= 1'b0;
                        cond_ready <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cond_ready <= 1'b1;
                    take_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_flag_cond_unit.sv
// tb/tb_flag_cond_unit.sv - scoreboard bench for flag_cond_unit
module tb_flag_cond_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flg_we = 1'b0;
    logic       sf_in = 1'b0, cf_in = 1'b0, of_in = 1'b0, pf_in = 1'b0, zf_in = 1'b0;
    logic       push = 1'b0, pop = 1'b0;
    logic       cond_valid = 1'b0;
    logic [3:0] cond_code = 4'd0;
    logic       take_ack = 1'b0;
    logic       cond_ready, take_valid, take;
    logic [4:0] flags_out;
    logic [2:0] stk_cnt;
    logic       stk_full, stk_empty, stk_err;

    int total = 0;
    int bad = 0;
    bit exp_q[$];
    logic tv_q = 1'b0;

    flag_cond_unit #(.STK_DEPTH(4), .STK_AW(2)) dut (
        .clk(clk), .rst_n(rst_n), .flg_we(flg_we),
        .sf_in(sf_in), .cf_in(cf_in), .of_in(of_in), .pf_in(pf_in), .zf_in(zf_in),
        .push(push), .pop(pop), .cond_valid(cond_valid), .cond_code(cond_code),
        .cond_ready(cond_ready), .take_valid(take_valid), .take(take), .take_ack(take_ack),
        .flags_out(flags_out), .stk_cnt(stk_cnt), .stk_full(stk_full),
        .stk_empty(stk_empty), .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_flags(input logic [4:0] v);
        {sf_in, cf_in, of_in, pf_in, zf_in} = v;
    endtask

    task automatic setf(input logic [4:0] v);
        drive_flags(v);
        flg_we = 1'b1;
        tick();
        flg_we = 1'b0;
    endtask

    task automatic do_push();
        push = 1'b1;
        tick();
        push = 1'b0;
    endtask

    task automatic do_pop();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic req(input logic [3:0] code, input bit exp);
        check("ready_before_req", {7'd0, cond_ready}, 8'd1);
        cond_valid = 1'b1;
        cond_code  = code;
        exp_q.push_back(exp);
        tick();
        cond_valid = 1'b0;
        check("busy_after_accept", {7'd0, cond_ready}, 8'd0);
        tick();
        check("tv_low_at_n1", {7'd0, take_valid}, 8'd0);
        tick();
        check("tv_high_at_n2", {7'd0, take_valid}, 8'd1);
        take_ack = 1'b1;
        tick();
        take_ack = 1'b0;
        check("tv_low_after_ack", {7'd0, take_valid}, 8'd0);
        check("ready_after_ack", {7'd0, cond_ready}, 8'd1);
    endtask

    // Monitor: compare take against the scoreboard on each new response.
    always @(negedge clk) begin
        if (take_valid && !tv_q) begin
            if (exp_q.size() == 0) begin
                check("unexpected_response", 8'd1, 8'd0);
            end else begin
                check("take", {7'd0, take}, {7'd0, exp_q.pop_front()});
            end
        end
        tv_q = take_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] pv [4];
        pv[0] = 5'h03; pv[1] = 5'h05; pv[2] = 5'h09; pv[3] = 5'h11;

        #12;
        check("rst_flags", {3'd0, flags_out}, 8'h00);
        check("rst_cnt", {5'd0, stk_cnt}, 8'd0);
        check("rst_tv", {7'd0, take_valid}, 8'd0);
        check("rst_err", {7'd0, stk_err}, 8'd0);
        rst_n = 1'b1;
        tick();
        check("rst_ready", {7'd0, cond_ready}, 8'd1);
        check("rst_empty", {7'd0, stk_empty}, 8'd1);

        // 1: BE and NBE
        setf(5'b01001);
        check("t1_flags", {3'd0, flags_out}, 8'h09);
        req(4'h6, 1'b1);
        req(4'h7, 1'b0);

        // 2: signed compares
        setf(5'b10000);
        req(4'hC, 1'b1);
        req(4'hF, 1'b0);
        setf(5'b10100);
        req(4'hD, 1'b1);

        // 3: stack fill, overflow, drain, underflow
        for (int i = 0; i < 4; i++) begin
            setf(pv[i]);
            do_push();
        end
        check("t3_full", {7'd0, stk_full}, 8'd1);
        check("t3_cnt4", {5'd0, stk_cnt}, 8'd4);
        push = 1'b1;
        tick();
        push = 1'b0;
        check("t3_ovf_err", {7'd0, stk_err}, 8'd1);
        check("t3_ovf_cnt", {5'd0, stk_cnt}, 8'd4);
        tick();
        check("t3_err_pulse", {7'd0, stk_err}, 8'd0);
        for (int i = 3; i >= 0; i--) begin
            do_pop();
            check("t3_pop_val", {3'd0, flags_out}, {3'd0, pv[i]});
        end
        check("t3_empty", {7'd0, stk_empty}, 8'd1);
        do_pop();
        check("t3_unf_err", {7'd0, stk_err}, 8'd1);
        check("t3_unf_flags", {3'd0, flags_out}, 8'h03);
        check("t3_unf_empty", {7'd0, stk_empty}, 8'd1);

        // 4: same-cycle interactions
        setf(5'b00000);
        drive_flags(5'b11111);
        flg_we = 1'b1;
        push = 1'b1;
        tick();
        flg_we = 1'b0;
        push = 1'b0;
        check("t4_push_we_fr", {3'd0, flags_out}, 8'h1F);
        check("t4_push_we_cnt", {5'd0, stk_cnt}, 8'd1);
        drive_flags(5'b10101);
        flg_we = 1'b1;
        pop = 1'b1;
        tick();
        flg_we = 1'b0;
        pop = 1'b0;
        check("t4_pop_we_fr", {3'd0, flags_out}, 8'h00);
        check("t4_pop_we_cnt", {5'd0, stk_cnt}, 8'd0);
        setf(5'h0A);
        do_push();
        push = 1'b1;
        pop = 1'b1;
        tick();
        push = 1'b0;
        pop = 1'b0;
        check("t4_pp_err", {7'd0, stk_err}, 8'd1);
        check("t4_pp_cnt", {5'd0, stk_cnt}, 8'd1);
        check("t4_pp_fr", {3'd0, flags_out}, 8'h0A);
        do_pop();
        check("t4_drain_cnt", {5'd0, stk_cnt}, 8'd0);

        // 5: accept-cycle flag write, long hold without re-evaluation
        cond_valid = 1'b1;
        cond_code = 4'h4;
        drive_flags(5'b00001);
        flg_we = 1'b1;
        exp_q.push_back(1'b1);
        tick();
        cond_valid = 1'b0;
        flg_we = 1'b0;
        tick();
        tick();
        setf(5'b00000);
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_tv", {7'd0, take_valid}, 8'd1);
            check("t5_hold_take", {7'd0, take}, 8'd1);
            check("t5_hold_ready", {7'd0, cond_ready}, 8'd0);
            if (i < 4) tick();
        end
        take_ack = 1'b1;
        tick();
        take_ack = 1'b0;
        check("t5_ack_tv", {7'd0, take_valid}, 8'd0);
        check("t5_ack_ready", {7'd0, cond_ready}, 8'd1);

        // 6: reset during EVAL with two stacked entries
        setf(5'h15);
        do_push();
        do_push();
        check("t6_cnt2", {5'd0, stk_cnt}, 8'd2);
        cond_valid = 1'b1;
        cond_code = 4'h0;
        tick();
        cond_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t6_tv", {7'd0, take_valid}, 8'd0);
        check("t6_cnt", {5'd0, stk_cnt}, 8'd0);
        check("t6_flags", {3'd0, flags_out}, 8'h00);
        #1;
        rst_n = 1'b1;
        tick();
        check("t6_ready", {7'd0, cond_ready}, 8'd1);
        tick();
        tick();
        check("t6_no_resp", {7'd0, take_valid}, 8'd0);
        check("sb_drained", 8'(exp_q.size()), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
